// File: rtl/load_store_unit.sv
// Multicycle RV32I load/store unit driving a word-addressed memory port.
// Optional LSU_MISALIGN_TRAP_EN: trap misaligned halfword/word accesses.
module load_store_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [1:0]  err_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_REQ,
    S_DONE,
    S_ERR
  } state_t;

  localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TLIM);
  localparam bit TMO_EN = (TIMEOUT > 0);

  state_t state;
  state_t nstate;

  logic [2:0]       f3_q;
  logic [1:0]       lo_q;
  logic [CNT_W-1:0] cnt;

  logic        ill;
  logic        mis;
  logic        tmo;
  logic        accept;
  logic        fail;
  logic        cap;
  logic [1:0]  cause_n;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic [7:0]  lane8;
  logic [15:0] lane16;
  logic [31:0] ld_data;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nstate;
  end

  // Next state and the one-cycle action strobes.
  always_comb begin
    nstate  = state;
    accept  = 1'b0;
    fail    = 1'b0;
    cap     = 1'b0;
    cause_n = 2'b00;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          accept = 1'b1;
          nstate = S_CHECK;
        end
      end
      S_CHECK: begin
        if (ill) begin
          fail    = 1'b1;
          cause_n = 2'b10;
          nstate  = S_ERR;
        end else if (mis) begin
          fail    = 1'b1;
          cause_n = 2'b01;
          nstate  = S_ERR;
        end else begin
          nstate = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          cap    = ~mem_we;
          nstate = S_DONE;
        end else if (tmo) begin
          fail    = 1'b1;
          cause_n = 2'b11;
          nstate  = S_ERR;
        end
      end
      S_DONE:  nstate = S_IDLE;
      S_ERR:   nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  assign busy    = (state == S_CHECK) | (state == S_REQ);
  assign done    = (state == S_DONE) | (state == S_ERR);
  assign mem_req = (state == S_REQ);
  assign tmo     = TMO_EN & (cnt == CNT_LIM);

  // Stores: illegal beyond SB/SH/SW. Loads: 011, 110, 111 illegal.
  always_comb begin
    ill = 1'b0;
    if (mem_we) ill = f3_q[2] | (f3_q[1:0] == 2'b11);
    else        ill = (f3_q == 3'b011) | (f3_q[2:1] == 2'b11);
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = ((f3_q[1:0] == 2'b01) & lo_q[0]) |
               ((f3_q[1:0] == 2'b10) & (lo_q != 2'b00));
`else
  assign mis = 1'b0;
`endif

  // Store lane strobes and replicated data, formed from the live command.
  always_comb begin
    st_strb = 4'b0000;
    st_data = wdata;
    if (we) begin
      case (funct3)
        3'b000: begin
          st_strb = 4'b0001 << addr[1:0];
          st_data = {4{wdata[7:0]}};
        end
        3'b001: begin
          st_strb = addr[1] ? 4'b1100 : 4'b0011;
          st_data = {2{wdata[15:0]}};
        end
        3'b010: begin
          st_strb = 4'b1111;
          st_data = wdata;
        end
        default: st_strb = 4'b0000;
      endcase
    end
  end

  // Load lane select and sign/zero extension of the returned word.
  always_comb begin
    case (lo_q)
      2'b00:   lane8 = mem_rdata[7:0];
      2'b01:   lane8 = mem_rdata[15:8];
      2'b10:   lane8 = mem_rdata[23:16];
      default: lane8 = mem_rdata[31:24];
    endcase
    lane16 = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{lane8[7]}}, lane8};
      3'b100:  ld_data = {24'h0, lane8};
      3'b001:  ld_data = {{16{lane16[15]}}, lane16};
      3'b101:  ld_data = {16'h0, lane16};
      default: ld_data = mem_rdata;
    endcase
  end

  // Command capture; the memory bundle stays frozen until the next start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f3_q      <= 3'b000;
      lo_q      <= 2'b00;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= 32'h0;
    end else if (accept) begin
      f3_q      <= funct3;
      lo_q      <= addr[1:0];
      mem_we    <= we;
      mem_addr  <= {addr[31:2], 2'b00};
      mem_wstrb <= st_strb;
      mem_wdata <= st_data;
    end
  end

  // Sticky error: cleared by an accepted start, set on entry to ERR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err       <= 1'b0;
      err_cause <= 2'b00;
    end else if (accept) begin
      err       <= 1'b0;
      err_cause <= 2'b00;
    end else if (fail) begin
      err       <= 1'b1;
      err_cause <= cause_n;
    end
  end

  // Wait counter: zeroed in CHECK, counts REQ cycles without ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         cnt <= '0;
    else if (state == S_CHECK)         cnt <= '0;
    else if (mem_req && !mem_ready)    cnt <= cnt + 1'b1;
  end

  // Load result, only updated by a completed load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    rdata <= 32'h0;
    else if (cap) rdata <= ld_data;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table, corner
// sequences and randomized accesses against a behavioural model.
module tb_load_store_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic [1:0]  err_cause;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  load_store_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .we        (we),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .err_cause (err_cause),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mword;
    int          delay;
    logic [1:0]  exp_cause;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] last_rd = 32'h0;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [2:0] f,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] m, input int dl,
                              input logic [1:0] c, input logic [3:0] s,
                              input logic [31:0] ewd,
                              input logic [31:0] erd);
    vec_t v;
    v.we = w; v.f3 = f; v.addr = a; v.wdata = d; v.mword = m;
    v.delay = dl; v.exp_cause = c; v.exp_strb = s;
    v.exp_wd = ewd; v.exp_rd = erd;
    return v;
  endfunction

  // Reference: access size in bytes, aligned lane offset, shifts/masks.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int sz;
    int off;
    logic illegal;
    logic misal;
    logic [31:0] mask;
    logic [31:0] val;
    r = v;
    sz = 1 << v.f3[1:0];
    off = int'(v.addr[1:0]);
    if (v.we) illegal = (v.f3 > 3'd2);
    else      illegal = (v.f3 == 3'd3) || (v.f3 >= 3'd6);
`ifdef LSU_MISALIGN_TRAP_EN
    misal = (off % sz) != 0;
`else
    misal = 1'b0;
`endif
    off = off - (off % sz);
    if (illegal)             r.exp_cause = 2'b10;
    else if (misal)          r.exp_cause = 2'b01;
    else if (v.delay >= TO)  r.exp_cause = 2'b11;
    else                     r.exp_cause = 2'b00;
    r.exp_strb = 4'b0000;
    r.exp_wd = 32'h0;
    r.exp_rd = 32'h0;
    if (v.we) begin
      r.exp_strb = 4'(((1 << sz) - 1) << off);
      for (int i = 0; i < 4; i++)
        r.exp_wd[8*i +: 8] = v.wdata[8*(i % sz) +: 8];
    end else begin
      mask = (sz >= 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
      val = (v.mword >> (8 * off)) & mask;
      if (!v.f3[2] && sz < 4 && val[8*sz-1]) val = val | ~mask;
      r.exp_rd = val;
    end
    return r;
  endfunction

  // One access from an IDLE negedge; returns at the next IDLE negedge.
  task automatic access(input vec_t v);
    int cyc;
    int c;
    logic fired;
    logic [31:0] ea;
    ea = {v.addr[31:2], 2'b00};
    start = 1'b1; we = v.we; funct3 = v.f3;
    addr = v.addr; wdata = v.wdata;
    mem_ready = 1'b0; mem_rdata = $urandom;
    @(negedge clk); cyc = 1;
    start = 1'b0;
    chk("check_state", {busy, done, mem_req}, {1'b1, 1'b0, 1'b0});
    chk("err_cleared", {err, err_cause}, 3'b000);
    @(negedge clk); cyc++;
    if (v.exp_cause == 2'b10 || v.exp_cause == 2'b01) begin
      chk("early_err", {busy, done, mem_req, err, err_cause},
          {1'b0, 1'b1, 1'b0, 1'b1, v.exp_cause});
      chk("err_rdata", rdata, last_rd);
    end else begin
      fired = 1'b0;
      for (c = 0; c < 64; c++) begin
        chk("req_bus", {mem_req, busy, done, mem_we, mem_wstrb, mem_addr},
            {1'b1, 1'b1, 1'b0, v.we, v.exp_strb, ea});
        if (v.we) chk("req_wdata", mem_wdata, v.exp_wd);
        if (c == v.delay) begin
          mem_ready = 1'b1;
          mem_rdata = v.mword;
          fired = 1'b1;
        end else begin
          mem_rdata = $urandom;
        end
        @(negedge clk); cyc++;
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        if (fired || c == TO - 1) break;
      end
      if (v.exp_cause == 2'b11) begin
        chk("timeout", {busy, done, mem_req, err, err_cause},
            {1'b0, 1'b1, 1'b0, 1'b1, 2'b11});
        chk("timeout_cycles", cyc, 2 + TO);
        chk("timeout_rdata", rdata, last_rd);
      end else begin
        chk("done_state", {busy, done, mem_req, err, err_cause},
            {1'b0, 1'b1, 1'b0, 1'b0, 2'b00});
        chk("latency", cyc, 3 + v.delay);
        if (!v.we) last_rd = v.exp_rd;
        chk("rdata", rdata, last_rd);
      end
    end
    @(negedge clk);
    chk("done_once", {done, busy, mem_req}, 3'b000);
    chk("err_sticky", {err, err_cause},
        {v.exp_cause != 2'b00, v.exp_cause});
  endtask

  initial begin
    vec_t v;
    int r;
    reset = 1'b1; start = 1'b0; we = 1'b0; funct3 = 3'b000;
    addr = 32'h0; wdata = 32'h0; mem_rdata = 32'h0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ctl", {busy, done, err, err_cause, mem_req, mem_we, mem_wstrb},
        11'h000);
    chk("reset_data", {rdata, mem_addr}, 64'h0);
    chk("reset_wdata", mem_wdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    tbl.push_back(mk(0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0,
                     2'b00, 4'h0, 0, 32'hDEADBEEF));
    tbl.push_back(mk(0, 3'b000, 32'h103, 0, 32'h80FF1234, 0,
                     2'b00, 4'h0, 0, 32'hFFFFFF80));
    tbl.push_back(mk(0, 3'b100, 32'h103, 0, 32'h80FF1234, 1,
                     2'b00, 4'h0, 0, 32'h00000080));
    tbl.push_back(mk(0, 3'b101, 32'h102, 0, 32'h80FF1234, 0,
                     2'b00, 4'h0, 0, 32'h000080FF));
    tbl.push_back(mk(1, 3'b000, 32'h201, 32'h000000A5, 0, 0,
                     2'b00, 4'b0010, 32'hA5A5A5A5, 0));
    tbl.push_back(mk(1, 3'b001, 32'h202, 32'h00001234, 0, 2,
                     2'b00, 4'b1100, 32'h12341234, 0));
    tbl.push_back(mk(0, 3'b010, 32'h104, 0, 32'h55555555, TO,
                     2'b11, 4'h0, 0, 0));
    tbl.push_back(mk(0, 3'b010, 32'h108, 0, 32'h11223344, TO - 1,
                     2'b00, 4'h0, 0, 32'h11223344));
`ifdef LSU_MISALIGN_TRAP_EN
    tbl.push_back(mk(0, 3'b010, 32'h102, 0, 32'hCAFEF00D, 0,
                     2'b01, 4'h0, 0, 0));
`else
    tbl.push_back(mk(0, 3'b010, 32'h102, 0, 32'hCAFEF00D, 0,
                     2'b00, 4'h0, 0, 32'hCAFEF00D));
`endif
    tbl.push_back(mk(0, 3'b011, 32'h100, 0, 0, 0, 2'b10, 4'h0, 0, 0));
    tbl.push_back(mk(0, 3'b001, 32'h106, 0, 32'hABCD0123, 0,
                     2'b00, 4'h0, 0, 32'hFFFFABCD));
    tbl.push_back(mk(1, 3'b010, 32'h300, 32'h01020304, 0, 0,
                     2'b00, 4'b1111, 32'h01020304, 0));
    tbl.push_back(mk(1, 3'b100, 32'h300, 32'h01020304, 0, 0,
                     2'b10, 4'h0, 0, 0));
`ifdef LSU_MISALIGN_TRAP_EN
    tbl.push_back(mk(1, 3'b001, 32'h203, 32'h0000BEEF, 0, 0,
                     2'b01, 4'h0, 0, 0));
`else
    tbl.push_back(mk(1, 3'b001, 32'h203, 32'h0000BEEF, 0, 0,
                     2'b00, 4'b1100, 32'hBEEFBEEF, 0));
`endif
    foreach (tbl[i]) access(tbl[i]);

    mem_ready = 1'b1; mem_rdata = 32'h5A5A5A5A;
    @(negedge clk);
    chk("idle_ready_ignored", {busy, done, mem_req, rdata},
        {1'b0, 1'b0, 1'b0, last_rd});
    mem_ready = 1'b0;

    start = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h400;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("req_before_rst", {mem_req, busy, mem_addr},
        {1'b1, 1'b1, 32'h400});
    start = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 32'h500;
    @(negedge clk);
    start = 1'b0;
    chk("start_ignored", {mem_req, busy, mem_we, mem_addr},
        {1'b1, 1'b1, 1'b0, 32'h400});
    #2 reset = 1'b1;
    #1;
    chk("rst_async", {mem_req, busy, done, err}, 4'b0000);
    chk("rst_regs", {mem_addr, rdata}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    last_rd = 32'h0;
    @(negedge clk);
    access(mk(0, 3'b010, 32'h440, 0, 32'h0BADF00D, 0,
              2'b00, 4'h0, 0, 32'h0BADF00D));

    for (int n = 0; n < 60; n++) begin
      v.we = 1'($urandom_range(0, 1));
      v.f3 = 3'($urandom_range(0, 7));
      v.addr = $urandom;
      v.wdata = $urandom;
      v.mword = $urandom;
      r = $urandom_range(0, 9);
      if (r < 7)       v.delay = r % 3;
      else if (r == 7) v.delay = TO - 1;
      else if (r == 8) v.delay = TO;
      else             v.delay = $urandom_range(0, TO - 2);
      access(model(v));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
